// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of mem_arbiter.
// The master side drives requests and RAM read data; the slave side is the arbiter.
interface mem_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic [31:0] ramRdata;
  logic        ramEn;
  logic        ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramWdata;
  logic        ifAck;
  logic        dmAck;
  logic [31:0] ifRdata;
  logic [31:0] dmRdata;
  logic        ifStall;
  logic        dmStall;

  modport master (
    output ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWdata, ramRdata,
    input  ramEn, ramWe, ramAddr, ramWdata, ifAck, dmAck, ifRdata, dmRdata, ifStall, dmStall
  );

  modport slave (
    input  ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWdata, ramRdata,
    output ramEn, ramWe, ramAddr, ramWdata, ifAck, dmAck, ifRdata, dmRdata, ifStall, dmStall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the fetch port and the MEM-stage port, WAIT cycles per access.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise the data port always wins.
module mem_arbiter #(
  parameter int unsigned WAIT = 2
) (
  input logic          clk,
  input logic          clr,
  mem_arbiter_if.slave bus
);

  // state    | meaning
  // IDLE     | RAM disabled, arbitrate pending requests
  // GRANT_IF | fetch access driven on RAM, wait counter running
  // GRANT_DM | data access driven on RAM, wait counter running
  // DONE     | granted port acked, RAM disabled
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       pick_dm;

`ifdef ARB_RR_EN
  logic ptr_dm;

  // ptr_dm set means the data port was not granted last and wins a tie
  always_comb pick_dm = bus.dmReq & (~bus.ifReq | ptr_dm);
`else
  always_comb pick_dm = bus.dmReq;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.ramEn    <= 1'b0;
      bus.ramWe    <= 1'b0;
      bus.ramAddr  <= '0;
      bus.ramWdata <= '0;
      bus.ifAck    <= 1'b0;
      bus.dmAck    <= 1'b0;
      bus.ifRdata  <= '0;
      bus.dmRdata  <= '0;
`ifdef ARB_RR_EN
      ptr_dm       <= 1'b1;
`endif
    end else begin
      bus.ifAck <= 1'b0;
      bus.dmAck <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_dm) begin
            state        <= GRANT_DM;
            cnt          <= 4'(WAIT - 1);
            bus.ramEn    <= 1'b1;
            bus.ramWe    <= bus.dmWe;
            bus.ramAddr  <= bus.dmAddr;
            bus.ramWdata <= bus.dmWdata;
`ifdef ARB_RR_EN
            ptr_dm       <= 1'b0;
`endif
          end else if (bus.ifReq) begin
            state        <= GRANT_IF;
            cnt          <= 4'(WAIT - 1);
            bus.ramEn    <= 1'b1;
            bus.ramWe    <= 1'b0;
            bus.ramAddr  <= bus.ifAddr;
`ifdef ARB_RR_EN
            ptr_dm       <= 1'b1;
`endif
          end
        end
        GRANT_IF, GRANT_DM: begin
          if (cnt == 4'd0) begin
            state     <= DONE;
            bus.ramEn <= 1'b0;
            bus.ramWe <= 1'b0;
            if (state == GRANT_IF) begin
              bus.ifRdata <= bus.ramRdata;
              bus.ifAck   <= 1'b1;
            end else begin
              // writes leave the data-port read register untouched
              if (!bus.ramWe) bus.dmRdata <= bus.ramRdata;
              bus.dmAck <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifStall = bus.ifReq & ~bus.ifAck;
  assign bus.dmStall = bus.dmReq & ~bus.dmAck;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT, 2, RAM access latency in cycles (legal 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 ifReq  input  1  fetch-stage read request, held until ifAck.
REQ-005 ifAddr  input  32  fetch byte address.
REQ-006 dmReq  input  1  MEM-stage request, held until dmAck.
REQ-007 dmWe  input  1  MEM-stage write (1) / read (0).
REQ-008 dmAddr  input  32  MEM-stage byte address.
REQ-009 dmWdata  input  32  MEM-stage write data.
REQ-010 ramRdata  input  32  shared single-port RAM read data, valid on the cycle the counter expires.
REQ-011 ramEn, ramWe  output  1 each  RAM enable, RAM write strobe.
REQ-012 ramAddr, ramWdata  output  32 each  RAM address, RAM write data.
REQ-013 ifAck, dmAck  output  1 each  one-cycle completion pulses.
REQ-014 ifRdata, dmRdata  output  32 each  registered read data, valid while the matching ack is high.
REQ-015 ifStall, dmStall  output  1 each  request pending and not yet acked.

Function
REQ-016 FSM states: IDLE, GRANT_IF, GRANT_DM, DONE.
REQ-017 IDLE: dmReq -> GRANT_DM; else ifReq -> GRANT_IF; else remain (priority per REQ-031/032).
REQ-018 Grant: address, write data and direction latched on the IDLE->GRANT edge; ramEn=1 and ramAddr/ramWe/ramWdata held constant for exactly WAIT cycles.
REQ-019 4-bit wait counter loads WAIT-1 on grant, decrements each cycle; at 0, FSM -> DONE.
REQ-020 Read data captured from ramRdata on the counter-0 cycle into the granted port's rdata register.
REQ-021 DONE: granted port's ack=1 for one cycle, ramEn=0, then -> IDLE; arbitration latency 1 cycle, request-to-ack latency WAIT+2 cycles.
REQ-022 ramWe=1 only in GRANT_DM with latched dmWe=1; a write updates no rdata register; dmAck still pulses.
REQ-023 ifStall = ifReq & ~ifAck; dmStall = dmReq & ~dmAck (combinational).
REQ-024 Request deasserted during its own grant: access completes, ack still pulses, no abort.
REQ-025 Request inputs changed during a grant are ignored until the next IDLE.
REQ-026 Both requests in IDLE: exactly one granted; the other stays stalled and is granted in the following IDLE.
REQ-027 ifAck and dmAck never high in the same cycle; ramEn=0 in IDLE and DONE.
REQ-028 rdata registers hold their value until overwritten by a later read of the same port.

Reset
REQ-029 clr=0 forces immediately: state IDLE, counter 0, all acks/ramEn/ramWe 0, ramAddr/ramWdata/ifRdata/dmRdata 0, priority pointer to data port.
REQ-030 Reset during a grant aborts the access: no ack issued; requester must re-present its request after release.

Configuration
REQ-031 Macro ARB_RR_EN defined: round-robin on simultaneous requests; a 1-bit pointer selects the port not granted last, updated on each grant.
REQ-032 ARB_RR_EN undefined: fixed priority, data port always wins; no pointer register is implemented.

Verification
REQ-033 WAIT=2, ifReq alone, ifAddr=0x10, ramRdata=0x8C080004 -> ramEn high 2 cycles with ramAddr=0x10; ifAck on cycle 4 with ifRdata=0x8C080004.
REQ-034 dmReq=1, dmWe=1, dmAddr=0x20, dmWdata=0xDEADBEEF -> ramWe=1 for 2 cycles at 0x20 with 0xDEADBEEF; dmAck pulse; dmRdata unchanged.
REQ-035 ifReq and dmReq rise in the same cycle, ARB_RR_EN undefined -> data granted first, ifStall high until the fetch is granted in the next IDLE; repeated simultaneous pairs always grant data first.
REQ-036 Same stimulus with ARB_RR_EN defined -> grants alternate DM, IF, DM, IF across four back-to-back simultaneous pairs.
REQ-037 clr pulsed low during the 2nd GRANT_DM cycle -> outputs zero asynchronously, no dmAck; after release a re-issued request completes normally.
REQ-038 WAIT=1 and WAIT=15 parameter sweep -> request-to-ack latency exactly 3 and 17 cycles.
